// File: rtl/alu_stage_pkg.sv
// Shared types and helpers for the ALU result stage: op encoding, buffer entry
// layout and the conditional-execution rules.
package alu_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int DEPTH  = 2;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADC  = 3'b001,
        OP_ADZ  = 3'b010,
        OP_NAND = 3'b100,
        OP_NDC  = 3'b101,
        OP_NDZ  = 3'b110
    } op_e;

    // op is kept as raw bits so the unused codes survive the buffer unchanged
    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] rd;
        logic [DATA_W:0]   res;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic is_add_fam(logic [2:0] op);
        return (op == OP_ADD) || (op == OP_ADC) || (op == OP_ADZ);
    endfunction

    function automatic logic is_known_op(logic [2:0] op);
        return op[1:0] != 2'b11;
    endfunction

    function automatic logic cond_ok(logic [2:0] op, logic c, logic z);
        logic ok;
        case (op)
            OP_ADD, OP_NAND: ok = 1'b1;
            OP_ADC, OP_NDC:  ok = c;
            OP_ADZ, OP_NDZ:  ok = z;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_result_fifo2.sv
// Generic two-entry valid/ready FIFO with synchronous flush. in_ready is a
// register (not full); a pop in the flush cycle still completes.
module alu_result_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         push_s, pop_s;

    assign push_s    = in_valid & ready_q & ~flush;
    assign pop_s     = (cnt_q != 2'd0) & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = cnt_q != 2'd0;
    assign out_data  = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push_s;
            rd_ptr_d = rd_ptr_q ^ pop_s;
            cnt_d    = cnt_q + 2'(push_s) - 2'(pop_s);
        end
        ready_d = cnt_d != 2'd2;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers EX results, resolves conditional ops against the
// architectural C/Z flags at the buffer head and presents writeback to WB.
// Optional ALU_STAGE_PERF_EN adds saturating exec/squash retire counters.
module alu_result_stage
    import alu_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W:0]   alu_res,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              cond_fail,
    output logic              carry_flag,
    output logic              zero_flag
`ifdef ALU_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_exec,
    output logic [CNT_W-1:0]  perf_squash
`endif
);

    entry_t in_entry_s;
    entry_t head_s;
    logic   head_valid_s;
    logic   retire_s;
    logic   exec_s;
    logic   squash_s;
    logic   carry_q, carry_d;
    logic   zero_q, zero_d;

    assign in_entry_s.op  = in_op;
    assign in_entry_s.rd  = in_rd;
    assign in_entry_s.res = alu_res;

    alu_result_fifo2 #(
        .W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry_s),
        .out_valid (head_valid_s),
        .out_ready (out_ready),
        .out_data  (head_s)
    );

    assign retire_s = head_valid_s & out_ready;

    // Head resolution and flag next-state; flags only move on an executing retire
    always_comb begin
        exec_s   = 1'b0;
        squash_s = 1'b0;
        wb_rd    = '0;
        wb_data  = '0;
        carry_d  = carry_q;
        zero_d   = zero_q;
        if (head_valid_s) begin
            exec_s   = cond_ok(head_s.op, carry_q, zero_q);
            squash_s = is_known_op(head_s.op) & ~exec_s;
            wb_rd    = head_s.rd;
            wb_data  = head_s.res[DATA_W-1:0];
        end else begin
            exec_s   = 1'b0;
            squash_s = 1'b0;
        end
        if (retire_s && exec_s) begin
            zero_d = head_s.res[DATA_W-1:0] == '0;
            if (is_add_fam(head_s.op)) begin
                carry_d = head_s.res[DATA_W];
            end else begin
                carry_d = carry_q;
            end
        end else begin
            zero_d = zero_q;
        end
    end

    // Architectural flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid  = head_valid_s;
    assign wb_en      = exec_s;
    assign cond_fail  = squash_s;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

`ifdef ALU_STAGE_PERF_EN
    logic [CNT_W-1:0] perf_exec_q, perf_exec_d;
    logic [CNT_W-1:0] perf_squash_q, perf_squash_d;

    // Saturating retire counters; flush does not clear them
    always_comb begin
        perf_exec_d   = perf_exec_q;
        perf_squash_d = perf_squash_q;
        if (retire_s && exec_s && (perf_exec_q != '1)) begin
            perf_exec_d = perf_exec_q + CNT_W'(1);
        end else begin
            perf_exec_d = perf_exec_q;
        end
        if (retire_s && squash_s && (perf_squash_q != '1)) begin
            perf_squash_d = perf_squash_q + CNT_W'(1);
        end else begin
            perf_squash_d = perf_squash_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_exec_q   <= '0;
            perf_squash_q <= '0;
        end else begin
            perf_exec_q   <= perf_exec_d;
            perf_squash_q <= perf_squash_d;
        end
    end

    assign perf_exec   = perf_exec_q;
    assign perf_squash = perf_squash_q;
`endif

endmodule
